// File: rtl/word_packer_pkg.sv
// Shared sizing and lane-placement helpers for the word packer.
package word_packer_pkg;

  // Width of the filled-lane count (must represent 0..ratio).
  function automatic int unsigned count_width(input int unsigned ratio);
    return $clog2(ratio + 1);
  endfunction

  // Width of the internal lane counter (0..ratio-1), at least one bit.
  function automatic int unsigned index_width(input int unsigned ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

  // Bit offset of a lane inside the packed word.
  function automatic int unsigned lane_offset(input int unsigned wd,
                                              input int unsigned ratio,
                                              input int unsigned lane,
                                              input bit          msb_first);
    return msb_first ? (ratio - 1 - lane) * wd : lane * wd;
  endfunction

endpackage

// File: rtl/word_packer_lane.sv
// One collector lane: WD-bit register with load enable and async clear.
module word_packer_lane #(
  parameter int unsigned WD = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [WD-1:0] d,
  output logic [WD-1:0] q
);

  // Capture the incoming word when this lane is the one being filled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/word_packer.sv
// Packs RATIO narrow words into one wide word; in_last flushes early.
module word_packer
  import word_packer_pkg::*;
#(
  parameter int unsigned WD        = 4,
  parameter int unsigned RATIO     = 3,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [WD-1:0]                   in_data,
  input  logic                            in_valid,
  input  logic                            in_last,
  output logic                            in_ready,
  output logic [WD*RATIO-1:0]             out_data,
  output logic [count_width(RATIO)-1:0]   out_count,
  output logic                            out_last,
  output logic                            out_valid,
  input  logic                            out_ready
);

  localparam int unsigned OW = count_width(RATIO);
  localparam int unsigned CW = index_width(RATIO);
  localparam int unsigned DW = WD * RATIO;
  localparam logic [CW-1:0] LAST_LANE = CW'(RATIO - 1);

  logic [CW-1:0] cnt;
  logic          accept;
  logic          complete;
  logic          store;
  logic [WD-1:0] nxt_lane [RATIO];
  logic [DW-1:0] nxt_data;

  // The output register can take a new word if empty or draining this cycle.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign complete = accept && (in_last || (cnt == LAST_LANE));
  assign store    = accept && !complete;

  // Collector lanes exist only when more than one word is packed.
  generate
    if (RATIO > 1) begin : g_coll
      logic [WD-1:0] coll [RATIO-1];
      for (genvar k = 0; k < RATIO - 1; k++) begin : g_lane
        word_packer_lane #(.WD(WD)) u_lane (
          .clk   (clk),
          .rst_n (rst_n),
          .load  (store && (cnt == CW'(k))),
          .d     (in_data),
          .q     (coll[k])
        );
        // Filled lanes from the collector, current lane from input, rest zero.
        assign nxt_lane[k] = (CW'(k) < cnt)  ? coll[k] :
                             (CW'(k) == cnt) ? in_data : '0;
      end
    end
  endgenerate

  // The top lane is never stored; it only ever comes straight from the input.
  assign nxt_lane[RATIO-1] = (cnt == LAST_LANE) ? in_data : '0;

  // Place each lane at its position in the packed word.
  always_comb begin
    nxt_data = '0;
    for (int unsigned k = 0; k < RATIO; k++) begin
      nxt_data[lane_offset(WD, RATIO, k, MSB_FIRST) +: WD] = nxt_lane[k];
    end
  end

  // Lane counter: advance on stored beats, restart on flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (complete) begin
      cnt <= '0;
    end else if (store) begin
      cnt <= cnt + CW'(1);
    end
  end

  // Output register: reload on flush takes priority over draining.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_count <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else if (complete) begin
      out_data  <= nxt_data;
      out_count <= OW'(cnt) + OW'(1);
      out_last  <= in_last;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_word_packer.sv
// Directed bench for word_packer: MSB/LSB placement, flush, stall, reset, RATIO=1.
module tb_word_packer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: WD=4, RATIO=3, MSB first
  logic [3:0]  a_in_data;
  logic        a_in_valid, a_in_last, a_in_ready;
  logic [11:0] a_out_data;
  logic [1:0]  a_out_count;
  logic        a_out_last, a_out_valid, a_out_ready;

  // Instance B: WD=4, RATIO=3, LSB first
  logic [3:0]  b_in_data;
  logic        b_in_valid, b_in_last, b_in_ready;
  logic [11:0] b_out_data;
  logic [1:0]  b_out_count;
  logic        b_out_last, b_out_valid, b_out_ready;

  // Instance C: WD=4, RATIO=1
  logic [3:0]  c_in_data;
  logic        c_in_valid, c_in_last, c_in_ready;
  logic [3:0]  c_out_data;
  logic [0:0]  c_out_count;
  logic        c_out_last, c_out_valid, c_out_ready;

  word_packer #(.WD(4), .RATIO(3), .MSB_FIRST(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .in_data(a_in_data), .in_valid(a_in_valid),
    .in_last(a_in_last), .in_ready(a_in_ready), .out_data(a_out_data),
    .out_count(a_out_count), .out_last(a_out_last), .out_valid(a_out_valid),
    .out_ready(a_out_ready));

  word_packer #(.WD(4), .RATIO(3), .MSB_FIRST(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .in_valid(b_in_valid),
    .in_last(b_in_last), .in_ready(b_in_ready), .out_data(b_out_data),
    .out_count(b_out_count), .out_last(b_out_last), .out_valid(b_out_valid),
    .out_ready(b_out_ready));

  word_packer #(.WD(4), .RATIO(1), .MSB_FIRST(1'b1)) u_c (
    .clk(clk), .rst_n(rst_n), .in_data(c_in_data), .in_valid(c_in_valid),
    .in_last(c_in_last), .in_ready(c_in_ready), .out_data(c_out_data),
    .out_count(c_out_count), .out_last(c_out_last), .out_valid(c_out_valid),
    .out_ready(c_out_ready));

  // Present one beat to A for one cycle (called at a negedge, returns at the next).
  task automatic send_a(input logic [3:0] d, input logic last);
    a_in_data  = d;
    a_in_last  = last;
    a_in_valid = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0;
    a_in_last  = 1'b0;
  endtask

  task automatic send_b(input logic [3:0] d, input logic last);
    b_in_data  = d;
    b_in_last  = last;
    b_in_valid = 1'b1;
    @(negedge clk);
    b_in_valid = 1'b0;
    b_in_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if (a_out_valid !== 1'b0 || a_out_data !== 12'h000 || a_out_count !== 2'd0 || a_out_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_a_outputs got v=%b d=%h c=%0d l=%b exp 0", a_out_valid, a_out_data, a_out_count, a_out_last);
    end
    checks++;
    if (a_in_ready !== 1'b1 || c_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got a=%b c=%b exp 1", a_in_ready, c_in_ready);
    end
    checks++;
    if (c_out_valid !== 1'b0 || c_out_count !== 1'b0) begin
      errors++;
      $display("FAIL reset_c_outputs got v=%b c=%0d exp 0", c_out_valid, c_out_count);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (a_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready got %b exp 1", a_in_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_msb_first();
    a_out_ready = 1'b1;
    send_a(4'hA, 1'b0);
    send_a(4'hB, 1'b0);
    send_a(4'hC, 1'b0);
    checks++;
    if (a_out_valid !== 1'b1 || a_out_data !== 12'hABC || a_out_count !== 2'd3 || a_out_last !== 1'b0) begin
      errors++;
      $display("FAIL msb_first got v=%b d=%h c=%0d l=%b exp v=1 d=abc c=3 l=0", a_out_valid, a_out_data, a_out_count, a_out_last);
    end
    @(negedge clk);
    checks++;
    if (a_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL msb_drain got v=%b exp 0", a_out_valid);
    end
  endtask

  task automatic test_lsb_first();
    b_out_ready = 1'b1;
    send_b(4'hA, 1'b0);
    send_b(4'hB, 1'b0);
    send_b(4'hC, 1'b0);
    checks++;
    if (b_out_valid !== 1'b1 || b_out_data !== 12'hCBA || b_out_count !== 2'd3 || b_out_last !== 1'b0) begin
      errors++;
      $display("FAIL lsb_first got v=%b d=%h c=%0d l=%b exp v=1 d=cba c=3 l=0", b_out_valid, b_out_data, b_out_count, b_out_last);
    end
    @(negedge clk);
  endtask

  task automatic test_partial_last();
    a_out_ready = 1'b1;
    send_a(4'h5, 1'b0);
    send_a(4'h6, 1'b1);
    checks++;
    if (a_out_valid !== 1'b1 || a_out_data !== 12'h560 || a_out_count !== 2'd2 || a_out_last !== 1'b1) begin
      errors++;
      $display("FAIL partial_last got v=%b d=%h c=%0d l=%b exp v=1 d=560 c=2 l=1", a_out_valid, a_out_data, a_out_count, a_out_last);
    end
    send_a(4'h1, 1'b0);
    send_a(4'h2, 1'b0);
    send_a(4'h3, 1'b0);
    checks++;
    if (a_out_valid !== 1'b1 || a_out_data !== 12'h123 || a_out_count !== 2'd3 || a_out_last !== 1'b0) begin
      errors++;
      $display("FAIL after_last_lane0 got v=%b d=%h c=%0d l=%b exp v=1 d=123 c=3 l=0", a_out_valid, a_out_data, a_out_count, a_out_last);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [11:0] got[$];
    logic        exp_rdy;
    int          idx;
    int          cyc;
    idx = 0;
    a_out_ready = 1'b0;
    // Stalled consumer: three beats fill the output register, then in_ready drops.
    for (int c = 0; c < 6; c++) begin
      a_in_valid = 1'b1;
      a_in_last  = 1'b0;
      a_in_data  = 4'(idx + 1);
      #1;
      exp_rdy = (c < 3);
      checks++;
      if (a_in_ready !== exp_rdy) begin
        errors++;
        $display("FAIL stall_in_ready cycle %0d got %b exp %b", c, a_in_ready, exp_rdy);
      end
      if (c >= 3) begin
        checks++;
        if (a_out_valid !== 1'b1 || a_out_data !== 12'h123 || a_out_count !== 2'd3) begin
          errors++;
          $display("FAIL stall_hold cycle %0d got v=%b d=%h c=%0d exp v=1 d=123 c=3", c, a_out_valid, a_out_data, a_out_count);
        end
      end
      if (a_in_ready) idx++;
      @(negedge clk);
    end
    // Release the consumer and stream the remaining beats.
    a_out_ready = 1'b1;
    cyc = 0;
    while ((idx < 9 || a_out_valid) && cyc < 20) begin
      if (idx < 9) begin
        a_in_valid = 1'b1;
        a_in_data  = 4'(idx + 1);
      end else begin
        a_in_valid = 1'b0;
      end
      #1;
      if (a_out_valid && a_out_ready) got.push_back(a_out_data);
      if (idx < 9) begin
        checks++;
        if (a_in_ready !== 1'b1) begin
          errors++;
          $display("FAIL stream_in_ready beat %0d got %b exp 1", idx, a_in_ready);
        end
        if (a_in_ready) idx++;
      end
      @(negedge clk);
      cyc++;
    end
    a_in_valid = 1'b0;
    checks++;
    if (cyc >= 20) begin
      errors++;
      $display("FAIL stream_timeout got %0d cycles exp <20", cyc);
    end
    checks++;
    if (got.size() != 3) begin
      errors++;
      $display("FAIL stream_count got %0d exp 3", got.size());
    end else begin
      checks++;
      if (got[0] !== 12'h123 || got[1] !== 12'h456 || got[2] !== 12'h789) begin
        errors++;
        $display("FAIL stream_data got %h %h %h exp 123 456 789", got[0], got[1], got[2]);
      end
    end
  endtask

  task automatic test_mid_reset();
    // Stalled output word is dropped immediately by reset.
    a_out_ready = 1'b0;
    send_a(4'hD, 1'b0);
    send_a(4'hE, 1'b0);
    send_a(4'hF, 1'b0);
    checks++;
    if (a_out_valid !== 1'b1 || a_out_data !== 12'hDEF) begin
      errors++;
      $display("FAIL pre_reset_word got v=%b d=%h exp v=1 d=def", a_out_valid, a_out_data);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (a_out_valid !== 1'b0 || a_out_data !== 12'h000 || a_out_count !== 2'd0 || a_out_last !== 1'b0 || a_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset got v=%b d=%h c=%0d l=%b r=%b exp 0 0 0 0 1", a_out_valid, a_out_data, a_out_count, a_out_last, a_in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    a_out_ready = 1'b1;
    // Partial collector is dropped by reset; next beat goes in lane 0.
    send_a(4'h1, 1'b0);
    send_a(4'h2, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (a_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL partial_reset_valid got %b exp 0", a_out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (a_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_release_ready got %b exp 1", a_in_ready);
    end
    send_a(4'h7, 1'b0);
    send_a(4'h8, 1'b0);
    send_a(4'h9, 1'b0);
    checks++;
    if (a_out_valid !== 1'b1 || a_out_data !== 12'h789 || a_out_count !== 2'd3) begin
      errors++;
      $display("FAIL post_reset_word got v=%b d=%h c=%0d exp v=1 d=789 c=3", a_out_valid, a_out_data, a_out_count);
    end
    @(negedge clk);
  endtask

  task automatic test_ratio1();
    logic [3:0] sb[$];
    logic [3:0] exp_d;
    int         nout;
    int         cyc;
    nout = 0;
    for (int c = 0; c < 300; c++) begin
      c_in_valid  = 1'($urandom_range(0, 1));
      c_in_data   = 4'($urandom_range(0, 15));
      c_in_last   = 1'($urandom_range(0, 1));
      c_out_ready = 1'($urandom_range(0, 1));
      #1;
      if (c_out_valid && c_out_ready) begin
        nout++;
        exp_d = (sb.size() > 0) ? sb.pop_front() : 4'hx;
        checks++;
        if (c_out_data !== exp_d || c_out_count !== 1'b1) begin
          errors++;
          $display("FAIL ratio1_word %0d got d=%h c=%0d exp d=%h c=1", nout, c_out_data, c_out_count, exp_d);
        end
      end
      if (c_in_valid && c_in_ready) sb.push_back(c_in_data);
      @(negedge clk);
    end
    c_in_valid  = 1'b0;
    c_out_ready = 1'b1;
    cyc = 0;
    while (c_out_valid && cyc < 10) begin
      #1;
      nout++;
      exp_d = (sb.size() > 0) ? sb.pop_front() : 4'hx;
      checks++;
      if (c_out_data !== exp_d || c_out_count !== 1'b1) begin
        errors++;
        $display("FAIL ratio1_drain %0d got d=%h c=%0d exp d=%h c=1", nout, c_out_data, c_out_count, exp_d);
      end
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (sb.size() != 0 || nout == 0) begin
      errors++;
      $display("FAIL ratio1_leftover got %0d pending %0d words exp 0 pending", sb.size(), nout);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    a_in_data = '0; a_in_valid = 1'b0; a_in_last = 1'b0; a_out_ready = 1'b1;
    b_in_data = '0; b_in_valid = 1'b0; b_in_last = 1'b0; b_out_ready = 1'b1;
    c_in_data = '0; c_in_valid = 1'b0; c_in_last = 1'b0; c_out_ready = 1'b1;
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_partial_last();
    test_back_to_back();
    test_mid_reset();
    test_ratio1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/word_packer.md
WORD_PACKER -- requirements
Module: word_packer

Interface
REQ-001 SHALL have parameter WD, default 4: input word width in bits, minimum 1.
REQ-002 SHALL have parameter RATIO, default 3: input words per output word, minimum 1.
REQ-003 SHALL have parameter MSB_FIRST, default 1: 1 = first word in the most-significant lane; 0 = first word in the least-significant lane.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_data  input  WD  input word.
REQ-007 SHALL have port in_valid  input  1  in_data/in_last valid.
REQ-008 SHALL have port in_last  input  1  current beat ends a packet; forces flush.
REQ-009 SHALL have port in_ready  output  1  packer accepts the beat this cycle.
REQ-010 SHALL have port out_data  output  WD*RATIO  packed word.
REQ-011 SHALL have port out_count  output  clog2(RATIO+1)  number of filled lanes, 1..RATIO.
REQ-012 SHALL have port out_last  output  1  packed word ends a packet.
REQ-013 SHALL have port out_valid  output  1  out_* valid.
REQ-014 SHALL have port out_ready  input  1  consumer accepts out_* this cycle.

Function
REQ-015 SHALL accept an input beat exactly when in_valid && in_ready; SHALL accept an output transfer exactly when out_valid && out_ready.
REQ-016 SHALL drive in_ready = !out_valid || out_ready (combinational from out_ready; no other combinational input-to-output path).
REQ-017 SHALL hold a collector of RATIO-1 lanes and a lane counter cnt in 0..RATIO-1.
REQ-018 SHALL, on an accepted beat with cnt < RATIO-1 and in_last=0, store in_data in lane cnt and increment cnt.
REQ-019 SHALL, on an accepted beat with cnt == RATIO-1 or in_last=1, load the output register with the collector plus in_data in lane cnt, zero all lanes above cnt, set out_count = cnt+1, set out_last = in_last, set out_valid=1, and reset cnt to 0, all in the same edge.
REQ-020 SHALL map lane k to out_data[WD*RATIO-1-k*WD -: WD] when MSB_FIRST=1, and to out_data[k*WD +: WD] when MSB_FIRST=0.
REQ-021 SHALL have latency of one cycle from the completing input beat to out_valid, and sustain one input beat per cycle while out_ready stays high.
REQ-022 SHALL clear out_valid after an output transfer unless REQ-019 reloads the register in the same edge; a reload takes priority.
REQ-023 SHALL hold out_data, out_count, out_last and out_valid stable while out_valid=1 and out_ready=0.
REQ-024 SHALL ignore in_data and in_last when in_valid=0 and leave collector contents unchanged.
REQ-025 SHALL, for RATIO=1, behave as a one-stage registered pipeline with out_count=1.

Reset
REQ-026 SHALL, while rst_n=0, force cnt=0, out_valid=0, out_last=0, out_count=0 and out_data=0 immediately, without a clock edge.
REQ-027 SHALL discard any partially filled collector and any unaccepted output word when reset is asserted mid-operation; the first beat after release goes in lane 0.
REQ-028 SHALL drive in_ready=1 throughout reset and on the first cycle after release.

Structure
REQ-029 SHALL place the lane-count width function (clog2(RATIO+1)) and the lane-offset helper in shared package word_packer_pkg.
REQ-030 SHALL implement each collector lane as sub-module word_packer_lane: a WD-bit register with load enable and asynchronous clear.
REQ-031 SHALL contain no latches and no combinational loops, and SHALL be synthesisable for all legal parameter values.

Verification
REQ-032 SHALL cover: WD=4, RATIO=3, MSB_FIRST=1, beats 0xA,0xB,0xC with out_ready=1 -> next cycle out_data=0xABC, out_count=3, out_last=0.
REQ-033 SHALL cover: same configuration with MSB_FIRST=0 -> out_data=0xCBA.
REQ-034 SHALL cover: beats 0x5, then 0x6 with in_last=1 -> out_data=0x560, out_count=2, out_last=1; the next beat lands in lane 0.
REQ-035 SHALL cover: out_ready=0 with nine beats offered back-to-back -> in_ready drops after the third beat, out_data is held, and raising out_ready resumes one beat per cycle with no loss or duplication.
REQ-036 SHALL cover: rst_n pulsed low after two beats 0x1,0x2 -> out_valid=0 at once; beats 0x7,0x8,0x9 after release -> 0x789.
REQ-037 SHALL cover: RATIO=1, random beats with random out_ready -> output stream equals input stream, each word with out_count=1.
